chunked_addsub: RTL

//   Parametrised add/subtract unit with carry and signed-overflow flags.

---
 rtl/chunked_addsub.sv | 88 ++++++++
 1 files changed

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract: WIDTH-bit operands summed CHUNK bits per cycle, LSB chunk first,
// with the ripple carry held in a register between chunks. Valid/ready on both sides.
module chunked_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             of
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, co_q, of_q;
  logic [CHUNK:0]   sum;
  logic             last;

  // One chunk of the ripple add; b_q already holds ~b for subtraction.
  assign sum  = {1'b0, a_q[cnt_q*CHUNK +: CHUNK]} + {1'b0, b_q[cnt_q*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
  assign last = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= sub ? ~b : b;
          carry_q <= sub ? 1'b1 : ci;
          cnt_q   <= '0;
        end
        RUN: begin
          s_q[cnt_q*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
          carry_q <= sum[CHUNK];
          cnt_q   <= cnt_q + 1'b1;
          // The final chunk carries the result MSB, so the flags resolve here.
          if (last) begin
            co_q <= sum[CHUNK];
            of_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sum[CHUNK-1] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign co        = co_q;
  assign of        = of_q;
endmodule
